// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline package: stage-register occupancy encoding and default payload widths.
// Every pipeline stage register imports this so all stages agree on encoding and sizing.
package pipe_stage_skid_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_CTRL_W = 16;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Main entry is valid in ONE and TWO.
  function automatic logic holds_main(input skid_state_e s);
    return (s != ST_EMPTY);
  endfunction

  // Skid slot is free unless both entries are occupied.
  function automatic logic can_accept(input skid_state_e s);
    return (s != ST_TWO);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             at_max;

  assign at_max = &count_reg;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && !at_max) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register (main + skid) with registered valid/ready, flush,
// and a saturating backpressure stall counter. Reused for every inter-stage boundary.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  skid_state_e       state_reg, state_next;
  logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic              out_valid_reg;
  logic              in_ready_reg;
  logic              accept;
  logic              send;

  assign accept = in_valid & in_ready_reg;
  assign send   = out_valid_reg & out_ready;

  // Control fields are forced to zero whenever their slot empties, so out_ctrl
  // is all zeros without needing an output mux on out_valid.
  always_comb begin
    state_next     = state_reg;
    main_ctrl_next = main_ctrl_reg;
    main_data_next = main_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    skid_data_next = skid_data_reg;
    if (flush) begin
      state_next     = ST_EMPTY;
      main_ctrl_next = '0;
      skid_ctrl_next = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next     = ST_ONE;
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end
        end
        ST_ONE: begin
          if (send && accept) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end else if (send) begin
            state_next     = ST_EMPTY;
            main_ctrl_next = '0;
          end else if (accept) begin
            state_next     = ST_TWO;
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so no accept can coincide with the skid move.
          if (send) begin
            state_next     = ST_ONE;
            main_ctrl_next = skid_ctrl_reg;
            main_data_next = skid_data_reg;
            skid_ctrl_next = '0;
          end
        end
        default: begin
          state_next     = ST_EMPTY;
          main_ctrl_next = '0;
          skid_ctrl_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      main_ctrl_reg <= main_ctrl_next;
      main_data_reg <= main_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      skid_data_reg <= skid_data_next;
      out_valid_reg <= holds_main(state_next);
      in_ready_reg  <= can_accept(state_next);
    end
  end

  assign out_valid = out_valid_reg;
  assign in_ready  = in_ready_reg;
  assign out_ctrl  = main_ctrl_reg;
  assign out_data  = main_data_reg;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stall_clr),
    .inc   (out_valid_reg & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed streaming/backpressure/flush/reset/
// saturation vectors followed by a random in_valid/out_ready/flush soak.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;
  logic          stall_clr;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];

  pipe_stage_skid #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge, return at the falling edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r,
                     input logic f, input logic c);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = d[CW-1:0] ^ 8'hA5;
    out_ready = r;
    flush     = f;
    stall_clr = c;
    @(negedge clk);
  endtask

  // Stimulus side: record every accepted entry; a flush or reset kills everything held.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back('{ctrl: in_ctrl, data: in_data});
    end
  end

  // Monitor side: every completed transfer must match the oldest outstanding entry.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && !flush && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual=%0h required=none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_ctrl !== e.ctrl) begin
          errors++;
          $display("FAIL out_entry actual=%0h/%0h required=%0h/%0h",
                   out_ctrl, out_data, e.ctrl, e.data);
        end
      end
    end else if (!rst && !out_valid) begin
      checks++;
      if (out_ctrl !== '0) begin
        errors++;
        $display("FAIL idle_ctrl actual=%0h required=0", out_ctrl);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; stall_clr = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    #1 rst = 1'b0;

    // Streaming: one transfer per cycle with 1-cycle latency.
    for (int i = 0; i < 8; i++) begin
      cyc(1, i, 1, 0, 0);
      chk("stream_in_ready", in_ready, 1);
      if (i == 0) chk("stream_first_valid", out_valid, 0);
      else begin
        chk("stream_valid", out_valid, 1);
        chk("stream_data", out_data, i - 1);
      end
    end
    cyc(0, 0, 1, 0, 0);
    chk("stream_last_data", out_data, 7);
    cyc(0, 0, 1, 0, 0);
    chk("stream_drained", out_valid, 0);
    chk("stream_no_stall", stall_cnt, 0);

    // Backpressure: A,B fill the stage, C is held upstream until space appears.
    cyc(1, 32'h10, 0, 0, 0);
    cyc(1, 32'h11, 0, 0, 0);
    chk("bp_one_ready", in_ready, 1);
    cyc(1, 32'h12, 0, 0, 0);
    chk("bp_two_ready", in_ready, 0);
    chk("bp_two_data", out_data, 32'h10);
    cyc(1, 32'h12, 0, 0, 0);
    chk("bp_hold_ready", in_ready, 0);
    cyc(1, 32'h12, 1, 0, 0);
    cyc(1, 32'h12, 1, 0, 0);
    chk("bp_b_data", out_data, 32'h11);
    cyc(0, 0, 1, 0, 0);
    chk("bp_c_data", out_data, 32'h12);
    cyc(0, 0, 1, 0, 0);
    chk("bp_drained", out_valid, 0);
    chk("bp_stall_cnt", stall_cnt, 3);

    // Flush while full with a simultaneous in_valid.
    cyc(1, 32'h20, 0, 0, 0);
    cyc(1, 32'h21, 0, 0, 0);
    cyc(1, 32'h22, 0, 1, 0);
    chk("fl_full_ready", in_ready, 0);
    cyc(0, 0, 1, 0, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_ctrl", out_ctrl, 0);
    chk("fl_in_ready", in_ready, 1);
    cyc(1, 32'h23, 1, 1, 0);
    cyc(1, 32'h24, 1, 0, 0);
    chk("fl_accept_dropped", out_valid, 0);
    cyc(0, 0, 1, 0, 0);
    chk("fl_next_data", out_data, 32'h24);
    cyc(0, 0, 1, 0, 0);
    chk("fl_queue_empty", exp_q.size(), 0);

    // Saturation of the 4-bit stall counter, then clear during a stall.
    cyc(1, 32'h30, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    chk("sat_max", stall_cnt, 15);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("sat_clr", stall_cnt, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("sat_drained", out_valid, 0);

    // Asynchronous reset between edges while the stage is full and stalled.
    cyc(1, 32'h40, 0, 0, 0);
    cyc(1, 32'h41, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ar_pre_stall", stall_cnt != 0, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_ctrl", out_ctrl, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc(0, 0, 1, 0, 0);
    chk("ar_post_valid", out_valid, 0);

    // Random soak against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of datapath payload (pc, alu result, store data, immediate, ...).
REQ-002 SHALL have parameter CTRL_W, default 16, width of control payload (reg_write, dest addr, mem read/write, WB select).
REQ-003 SHALL have parameter CNT_W, default 16, width of stall-cycle counter.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held entries (branch mispredict / trap).
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_ready  output  1  stage can accept; registered, depends only on internal state.
REQ-009 SHALL have port in_ctrl  input  CTRL_W  upstream control field.
REQ-010 SHALL have port in_data  input  DATA_W  upstream data field.
REQ-011 SHALL have port out_valid  output  1  entry presented downstream.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_ctrl  output  CTRL_W  control of presented entry; all zeros when out_valid=0.
REQ-014 SHALL have port out_data  output  DATA_W  data of presented entry; don't-care when out_valid=0.
REQ-015 SHALL have port stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
REQ-016 SHALL have port stall_clr  input  1  synchronous clear of stall_cnt.

Function
REQ-017 SHALL hold two entries: main (drives outputs) and skid; states EMPTY, ONE (main valid), TWO (main+skid valid).
REQ-018 SHALL define accept = in_valid & in_ready, and send = out_valid & out_ready.
REQ-019 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on send without accept; ONE->ONE on send with accept (main reloaded); ONE->TWO on accept without send (input to skid); TWO->ONE on send (skid moves to main).
REQ-020 SHALL drive in_ready=1 in EMPTY and ONE, 0 in TWO.
REQ-021 SHALL give latency of exactly 1 cycle from accept to out_valid when stage EMPTY, and sustain one transfer per cycle while out_ready=1.
REQ-022 SHALL preserve order: skid entry always presented after the main entry it queued behind.
REQ-023 SHALL, on flush=1, go to EMPTY next cycle, zero both ctrl fields, discard any same-cycle accept; flush overrides every other event.
REQ-024 SHALL not assert out_valid combinationally from in_valid (registered output, no bypass).
REQ-025 SHALL increment stall_cnt when out_valid=1 and out_ready=0, saturating at all-ones; stall_clr takes priority over increment; flush does not clear it.
REQ-026 SHALL never lose or duplicate an entry for any in_valid/out_ready pattern.

Reset
REQ-027 SHALL on rst enter EMPTY: out_valid=0, in_ready=1, out_ctrl=0, out_data=0, skid ctrl/data=0, stall_cnt=0.
REQ-028 SHALL, when rst asserts mid-operation, drop all held entries immediately (asynchronous) with no transfer completing in that cycle.

Structure
REQ-029 SHALL place state encoding (EMPTY/ONE/TWO) and default DATA_W/CTRL_W constants in the shared pipeline package used by all stage registers.
REQ-030 SHALL implement stall counter as sub-module sat_counter (parameter CNT_W; inc, clr inputs).
REQ-031 SHALL be instantiable for IF/ID, ID/EX, EX/MEM, MEM/WB by parameter choice only.

Verification
REQ-032 SHALL test streaming: in_valid=1, out_ready=1, 8 entries data 0..7 -> out_data 0..7 on consecutive cycles, 1-cycle latency, in_ready stays 1.
REQ-033 SHALL test backpressure: out_ready=0, send A,B -> state TWO, in_ready=0 next cycle, C held by upstream; out_ready=1 -> A,B,C in order, stall_cnt counted exactly the stalled cycles.
REQ-034 SHALL test flush in TWO with simultaneous in_valid: next cycle out_valid=0, out_ctrl=0, in_ready=1, flushed and same-cycle entries never appear.
REQ-035 SHALL test async reset mid-stream: rst pulse between clock edges -> outputs at reset values before next edge, stall_cnt=0.
REQ-036 SHALL test saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15; stall_clr with stall same cycle -> 0.
REQ-037 SHALL run random in_valid/out_ready/flush for 10k cycles against a scoreboard -> no loss, duplication or reordering.
